// File: rtl/elbeth_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// elbeth_fetch_sequencer
//
// Program-counter controller for the ELBETH fetch stage. Owns the PC, issues
// instruction-memory requests and hands fetched words to decode.
//
// Handshakes:
//   imem side : imem_req_o is high in FETCH; imem_addr_o (== pc) is stable
//               until imem_ready_i completes the request. imem_rdata_i is
//               only consumed on a cycle with imem_req_o & imem_ready_i and
//               no higher-priority event (exception, redirect, stall-hold).
//   decode side: instr_o/pc_o/pc_plus4_o are meaningful while valid_o is
//               high; while stall_i & valid_o they are held unchanged.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   stall_i           decode cannot accept; hold outputs
//   redirect_i/_pc_i  taken branch/jump and its target
//   exception_i       exception request (highest priority)
//   imem_req_o        fetch request
//   imem_addr_o       fetch address (internal pc)
//   imem_ready_i      completes the request, imem_rdata_i valid
//   imem_rdata_i      fetched instruction word
//   valid_o           decode outputs valid
//   instr_o, pc_o     instruction and its address
//   pc_plus4_o        pc_o + 4 (link value)
//   epc_o             pc_o captured when an exception is taken
//   dbg_state_o       current FSM state (0 BOOT, 1 FETCH, 2 HOLD)
// ----------------------------------------------------------------------------
module elbeth_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        exception_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] epc_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pco_q;
    logic [31:0] pc4_q;
    logic [31:0] epc_q;

    // Event decode, already resolved by priority. BOOT ignores all inputs.
    logic active;
    logic take_exc;
    logic take_redir;
    logic take_stall;
    logic take_word;
    logic take_bubble;

    always_comb begin
        active      = (state_q != ST_BOOT);
        take_exc    = active & exception_i;
        take_redir  = active & ~exception_i & redirect_i;
        // A stall only matters when there is something valid to hold.
        take_stall  = active & ~exception_i & ~redirect_i & stall_i & valid_q;
        take_word   = (state_q == ST_FETCH) & ~exception_i & ~redirect_i
                      & ~(stall_i & valid_q) & imem_ready_i;
        take_bubble = (state_q == ST_FETCH) & ~exception_i & ~redirect_i
                      & ~(stall_i & valid_q) & ~imem_ready_i;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH,
            ST_HOLD: begin
                if (take_exc || take_redir) begin
                    state_d = ST_FETCH;
                end else if (take_stall) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_o  = (state_q == ST_FETCH);
        imem_addr_o = pc_q;
        dbg_state_o = state_q;
        valid_o     = valid_q;
        instr_o     = instr_q;
        pc_o        = pco_q;
        pc_plus4_o  = pc4_q;
        epc_o       = epc_q;
    end

    // PC and decode-facing registers. Anything not named in a branch holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pco_q   <= 32'd0;
            pc4_q   <= 32'd0;
            epc_q   <= 32'd0;
        end else if (take_exc) begin
            pc_q    <= EXC_VECTOR;
            epc_q   <= pco_q;
            valid_q <= 1'b0;
        end else if (take_redir) begin
            // Targets are forced word-aligned.
            pc_q    <= redirect_pc_i & 32'hFFFF_FFFC;
            valid_q <= 1'b0;
        end else if (take_word) begin
            instr_q <= imem_rdata_i;
            pco_q   <= pc_q;
            pc4_q   <= pc_q + 32'd4;
            pc_q    <= pc_q + 32'd4;
            valid_q <= 1'b1;
        end else if (take_bubble) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_elbeth_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_elbeth_fetch_sequencer
//
// Driver applies inputs on the falling edge and advances a behavioural model
// of the fetch stage from the same inputs, pushing the expected post-edge
// outputs into queues. A monitor pops and compares one entry after every
// rising edge (control/address view) and one entry per cycle decode sees
// valid_o (delivered instruction view).
// ----------------------------------------------------------------------------
module tb_elbeth_fetch_sequencer;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        exception_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] epc_o;
    logic [1:0]  dbg_state_o;

    elbeth_fetch_sequencer #(
        .RESET_VECTOR(RESET_VECTOR),
        .EXC_VECTOR  (EXC_VECTOR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .exception_i  (exception_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i),
        .valid_o      (valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .epc_o        (epc_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    // ctrl entry: {req, addr, valid, epc}; word entry: {instr, pc, pc+4}
    logic [65:0] exp_q[$];
    logic [95:0] exp_word_q[$];
    int vectors     = 0;
    int miscompares = 0;
    bit drv_done    = 1'b0;
    bit mon_done    = 1'b0;

    // ---------------- reference model ----------------
    // Phase of the fetch stage: just out of reset, requesting, or holding
    // decode while it stalls.
    typedef enum int {M_BOOT, M_FETCH, M_HOLD} mode_t;
    mode_t       m_mode  = M_BOOT;
    logic [31:0] m_pc    = RESET_VECTOR;
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pco   = 32'd0;
    logic [31:0] m_pc4   = 32'd0;
    logic [31:0] m_epc   = 32'd0;

    task automatic model_step();
        if (!rst_n) begin
            m_mode = M_BOOT; m_pc = RESET_VECTOR; m_valid = 1'b0;
            m_instr = 32'd0; m_pco = 32'd0; m_pc4 = 32'd0; m_epc = 32'd0;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_FETCH;
        end else if (exception_i) begin
            m_epc = m_pco; m_pc = EXC_VECTOR; m_valid = 1'b0; m_mode = M_FETCH;
        end else if (redirect_i) begin
            m_pc = {redirect_pc_i[31:2], 2'b00}; m_valid = 1'b0; m_mode = M_FETCH;
        end else if (stall_i && m_valid) begin
            m_mode = M_HOLD;
        end else if (m_mode == M_HOLD) begin
            m_mode = M_FETCH;
        end else if (imem_ready_i) begin
            m_instr = imem_rdata_i;
            m_pco   = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit rst, input bit st, input bit rd,
                         input logic [31:0] rpc, input bit ex, input bit rdy);
        @(negedge clk);
        rst_n         = ~rst;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        exception_i   = ex;
        imem_ready_i  = rdy;
        imem_rdata_i  = $urandom;
        model_step();
        exp_q.push_back({(m_mode == M_FETCH), m_pc, m_valid, m_epc});
        if (m_valid) exp_word_q.push_back({m_instr, m_pco, m_pc4});
    endtask

    task automatic run_ready(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 32'd0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        exception_i = 1'b0; imem_ready_i = 1'b0; imem_rdata_i = 32'd0;

        // Reset/boot with ready held high.
        drive(1, 0, 0, 32'd0, 0, 1);
        drive(1, 0, 0, 32'd0, 0, 1);
        run_ready(6);

        // Wait states: ready every third cycle.
        drive(1, 0, 0, 32'd0, 0, 0);
        drive(1, 0, 0, 32'd0, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 32'd0, 0, (i % 3) == 2);

        // Stall while pc_o == 8 is in decode.
        drive(1, 0, 0, 32'd0, 0, 1);
        drive(1, 0, 0, 32'd0, 0, 1);
        for (int i = 0; i < 20 && !(m_valid && m_pco == 32'h8); i++) run_ready(1);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 32'd0, 0, 1);
        run_ready(4);

        // Redirect to a misaligned target concurrent with ready.
        drive(0, 0, 1, 32'h0000_1003, 0, 1);
        run_ready(3);

        // Exception and redirect together while pc_o == 0x20.
        drive(0, 0, 1, 32'h0000_0020, 0, 1);
        run_ready(1);
        drive(0, 0, 1, 32'h0000_0500, 1, 1);
        run_ready(3);

        // Wrap at the top of the address space.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
        run_ready(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 11) == 0,
                  tgt,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 6);
        end

        drv_done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            miscompares++;
            $display("FAIL monitor_timeout: got mon_done=0, expected 1");
        end
        if (exp_word_q.size() != 0) begin
            miscompares++;
            $display("FAIL word_leftover: got %0d undelivered words, expected 0",
                     exp_word_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        logic [65:0] e;
        logic [95:0] w;
        // The edge before the first drive has no expectation behind it.
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (drv_done) break;
                miscompares++;
                $display("FAIL ctrl_underflow @%0t: no expectation queued", $time);
                continue;
            end
            e = exp_q.pop_front();
            vectors++;
            if ({imem_req_o, imem_addr_o, valid_o, epc_o} !== e) begin
                miscompares++;
                $display("FAIL ctrl @%0t: got req=%0b addr=%h valid=%0b epc=%h, expected req=%0b addr=%h valid=%0b epc=%h",
                         $time, imem_req_o, imem_addr_o, valid_o, epc_o,
                         e[65], e[64:33], e[32], e[31:0]);
            end
            if (valid_o === 1'b1) begin
                if (exp_word_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL word_underflow @%0t: got valid word pc=%h, expected none",
                             $time, pc_o);
                end else begin
                    w = exp_word_q.pop_front();
                    vectors++;
                    if ({instr_o, pc_o, pc_plus4_o} !== w) begin
                        miscompares++;
                        $display("FAIL word @%0t: got instr=%h pc=%h pc4=%h, expected instr=%h pc=%h pc4=%h",
                                 $time, instr_o, pc_o, pc_plus4_o, w[95:64], w[63:32], w[31:0]);
                    end
                end
            end
        end
        mon_done = 1'b1;
    end

endmodule

// File: doc/elbeth_fetch_sequencer.md
Name: elbeth_fetch_sequencer

Overview:
Program-counter controller for the ELBETH fetch stage. It owns the PC register and issues instruction-memory requests with a req/ready handshake. It selects the next PC from sequential PC+4, branch/jump redirect, or exception vector, and presents fetched instruction, PC and PC+4 to decode with a valid/stall handshake.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
EXC_VECTOR, 32'h0000_0080, PC loaded on exception.

Ports:
clk  input  1  core clock; all state changes on rising edge.
rst_n  input  1  synchronous reset, active-low.
stall_i  input  1  decode cannot accept; hold outputs.
redirect_i  input  1  taken branch/jump this cycle.
redirect_pc_i  input  32  branch/jump target.
exception_i  input  1  exception request; highest priority.
imem_req_o  output  1  instruction fetch request.
imem_addr_o  output  32  fetch address; equals internal pc.
imem_ready_i  input  1  imem_rdata_i valid; completes the request.
imem_rdata_i  input  32  fetched instruction word.
valid_o  output  1  instr_o/pc_o valid for decode.
instr_o  output  32  fetched instruction.
pc_o  output  32  address of instr_o.
pc_plus4_o  output  32  pc_o + 4, for link writes.
epc_o  output  32  PC of the instruction in decode when the exception was taken.

Behaviour:
- States: BOOT, FETCH, HOLD. Reset (rst_n=0 at edge): state=BOOT, pc=RESET_VECTOR, valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0, epc_o=0. Reset mid-request abandons it; a late imem_ready_i is ignored.
- BOOT: imem_req_o=0 for exactly one cycle, then FETCH.
- imem_req_o = (state==FETCH). imem_addr_o=pc at all times, stable while req is high and ready is low.
- Per-cycle priority, in states FETCH and HOLD: exception_i > redirect_i > (stall_i & valid_o) > imem_ready_i.
- exception_i: pc<=EXC_VECTOR, epc_o<=pc_o, valid_o<=0, state<=FETCH. Any same-cycle imem_ready_i response is discarded.
- redirect_i (no exception): pc<={redirect_pc_i[31:2],2'b00}, valid_o<=0, state<=FETCH. Same-cycle response is discarded.
- stall_i with valid_o=1: outputs and pc are held, state<=HOLD. A same-cycle imem_ready_i response is discarded and that address is refetched later. stall_i with valid_o=0 is ignored.
- HOLD: imem_req_o=0. Return to FETCH the cycle after stall_i drops, with outputs unchanged.
- FETCH, imem_ready_i=1, no higher event: instr_o<=imem_rdata_i, pc_o<=pc, pc_plus4_o<=pc+4, valid_o<=1, pc<=pc+4.
- FETCH, imem_ready_i=0: valid_o<=0 (bubble), pc unchanged. Memory latency is unbounded.
- Throughput: one instruction per cycle when imem_ready_i is held high. Latency: address to valid_o is 1 cycle after ready.
- Arithmetic: 32-bit modulo. pc 32'hFFFF_FFFC+4 wraps to 0, and pc_plus4_o wraps identically. No overflow flag.
- Alignment: pc[1:0] is always 00. Parameters must be word-aligned.

Test Plan:
- Reset/boot: rst_n=0 for 2 cycles, release, imem_ready_i=1 constant -> req low 1 cycle, then addresses 0,4,8,C on consecutive cycles. valid_o rises the cycle after the first ready with pc_o=0, pc_plus4_o=4.
- Wait states: ready every 3rd cycle -> imem_addr_o holds each address until ready; valid_o pulses once per word; pc_o sequence is 0,4,8.
- Stall: assert stall_i 3 cycles while valid_o=1 with pc_o=8 -> instr_o/pc_o held, req low in HOLD. Resume fetch at 0xC with no skipped or duplicated instruction.
- Redirect: redirect_i with target 32'h0000_1003 concurrent with ready -> response dropped, valid_o=0 next cycle, next fetch at 0x1000.
- Exception + redirect same cycle, pc_o=0x20 -> pc=0x80, epc_o=0x20, redirect ignored.
- Wrap: redirect to 32'hFFFF_FFFC, ready high -> pc_o=FFFF_FFFC with pc_plus4_o=0, next fetch address 0.
